// File: rtl/tx_gearbox_sequencer.sv
// Sequencing controller for the 32-bit 64b/66b transmit path.
// Tracks the two-word block phase and the gearbox sequence (0..SEQ_MAX).
// Sequence value SEQ_MAX is the pause block: the encoder/scrambler is held
// for two cycles, and the MAC is held for two cycles PAUSE_LEAD cycles earlier.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | not sequencing, all outputs low (slip count retained)
//   ST_RUN   | normal blocks, sequence 0..SEQ_MAX-1
//   ST_PAUSE | gearbox pause block, sequence = SEQ_MAX, encoder held
module tx_gearbox_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_MAX    = 32,
    parameter int PAUSE_LEAD = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_resync,
    output logic        o_xgmii_pause,
    output logic        o_enc_pause,
    output logic        o_block_phase,
    output logic [5:0]  o_gb_seq,
    output logic        o_hdr_valid,
    output logic        o_running,
    output logic [15:0] o_slip_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [5:0] SEQ_LAST  = 6'(SEQ_MAX - 1);
    localparam logic [5:0] SEQ_PAUSE = 6'(SEQ_MAX);

    // Position within the period is {seq, phase}; the MAC pause window is
    // the two positions that end PAUSE_LEAD cycles before the pause block ends.
    localparam logic [6:0] XG_FIRST = 7'(2 * SEQ_MAX - PAUSE_LEAD);
    localparam logic [6:0] XG_LAST  = 7'(2 * SEQ_MAX + 1 - PAUSE_LEAD);

    if (DATA_WIDTH != 32 || PAUSE_LEAD < 0 || PAUSE_LEAD > 2 || SEQ_MAX < 2 || SEQ_MAX > 63) begin : g_bad_cfg
        $error("tx_gearbox_sequencer: unsupported parameter set");
    end

    logic [1:0] state, state_n;
    logic       start_q, start_n;
    logic       dis_pend, dis_n;
    logic       rs_pend, rs_n;
    logic       phase_n;
    logic [5:0] seq_n;
    logic [6:0] pos_n;
    logic       dis_req, rs_req;
    logic       xg_n, enc_n, hdr_n, run_n;
    logic       slip_inc;

    // A disable or resync request counts from the cycle it is sampled.
    assign dis_req = dis_pend | ~i_enable;
    assign rs_req  = rs_pend | i_resync;

    // Next-state decode; all decisions other than the phase toggle happen
    // on phase-1 cycles so that they take effect at a block boundary.
    always_comb begin
        state_n = state;
        phase_n = o_block_phase;
        seq_n   = o_gb_seq;
        start_n = 1'b0;
        dis_n   = dis_pend;
        rs_n    = rs_pend;

        if (state == ST_IDLE) begin
            // One cycle of enable qualification before sequencing starts.
            if (start_q && i_enable) begin
                state_n = ST_RUN;
                phase_n = 1'b0;
                seq_n   = 6'd0;
            end else begin
                start_n = i_enable;
            end
        end else if (state == ST_RUN || state == ST_PAUSE) begin
            dis_n = dis_req;
            rs_n  = rs_req;
            if (!o_block_phase) begin
                phase_n = 1'b1;
            end else begin
                phase_n = 1'b0;
                if (state == ST_PAUSE) begin
                    // The wrap to 0 already satisfies any pending resync.
                    seq_n   = 6'd0;
                    rs_n    = 1'b0;
                    state_n = dis_req ? ST_IDLE : ST_RUN;
                end else if (o_xgmii_pause) begin
                    // MAC has already been told to pause: the pause block must follow.
                    state_n = ST_PAUSE;
                    seq_n   = SEQ_PAUSE;
                end else if (dis_req) begin
                    state_n = ST_IDLE;
                end else if (rs_req) begin
                    seq_n = 6'd0;
                    rs_n  = 1'b0;
                end else if (o_gb_seq == SEQ_LAST) begin
                    state_n = ST_PAUSE;
                    seq_n   = SEQ_PAUSE;
                end else begin
                    seq_n = o_gb_seq + 6'd1;
                end
            end
        end else begin
            state_n = ST_IDLE;
        end

        if (state_n == ST_IDLE) begin
            dis_n   = 1'b0;
            rs_n    = 1'b0;
            phase_n = 1'b0;
            seq_n   = 6'd0;
        end
    end

    // Output values for the next cycle, derived from the next state so that
    // every output comes straight from a flop.
    always_comb begin
        pos_n = {seq_n, phase_n};
        run_n = (state_n != ST_IDLE);
        xg_n  = run_n && (pos_n >= XG_FIRST) && (pos_n <= XG_LAST);
        enc_n = (state_n == ST_PAUSE);
        hdr_n = (state_n == ST_RUN) && !phase_n;
    end

    // Control state and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            start_q       <= 1'b0;
            dis_pend      <= 1'b0;
            rs_pend       <= 1'b0;
            o_block_phase <= 1'b0;
            o_gb_seq      <= 6'd0;
            o_xgmii_pause <= 1'b0;
            o_enc_pause   <= 1'b0;
            o_hdr_valid   <= 1'b0;
            o_running     <= 1'b0;
        end else begin
            state         <= state_n;
            start_q       <= start_n;
            dis_pend      <= dis_n;
            rs_pend       <= rs_n;
            o_block_phase <= phase_n;
            o_gb_seq      <= seq_n;
            o_xgmii_pause <= xg_n;
            o_enc_pause   <= enc_n;
            o_hdr_valid   <= hdr_n;
            o_running     <= run_n;
        end
    end

    assign slip_inc = (state == ST_PAUSE) && o_block_phase && (o_slip_cnt != 16'hFFFF);

    // Saturating count of completed pause blocks.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_slip_cnt <= 16'd0;
        end else if (slip_inc) begin
            o_slip_cnt <= o_slip_cnt + 16'd1;
        end
    end

endmodule
